axis_pad_packet_tx: RTL and testbench

Transmit-side framer that feeds the overlap-add packet processor's AXI-Stream slave port. It buffers a raw byte stream in an internal FIFO and emits packets of `len` beats. Each packet carries `len-k` payload bytes followed by `k` zero pad bytes, and `m_last` is asserted on the final beat. The zero tail is the region the downstream processor overlap-adds.

---
 rtl/axis_pad_packet_tx.sv | 208 ++++++++++++++++++++
 tb/tb_axis_pad_packet_tx.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_pad_packet_tx.sv
`default_nettype none
// ============================================================================
// Module  : axis_pad_packet_tx
// Purpose : Queues a raw byte stream in a FIFO and frames it into AXI-Stream
//           packets of len beats, the last k of which are zero pad. Zero
//           padding is compiled in only when PKT_TX_PAD_EN is defined.
// Rev     : 1.0  initial release
// ============================================================================

module axis_pad_packet_tx #(
    parameter int Data_width = 8,
    parameter int Depth      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [Data_width-1:0] wr_data_i,
    input  logic                  wr_en_i,
    output logic                  wr_ready_o,
    input  logic [Data_width-1:0] len_i,
    input  logic [Data_width-1:0] k_i,
    output logic [Data_width-1:0] m_data_o,
    output logic                  m_valid_o,
    output logic                  m_last_o,
    input  logic                  m_ready_i,
    output logic                  full_o,
    output logic                  empty_o,
    output logic                  cfg_err_o
);

    localparam int              c_AW      = $clog2(Depth);
    localparam logic [c_AW:0]   c_DEPTH   = {1'b1, {c_AW{1'b0}}};
    localparam logic [c_AW:0]   c_PTR_ONE = {{c_AW{1'b0}}, 1'b1};
    localparam logic [Data_width-1:0] c_ONE = {{(Data_width-1){1'b0}}, 1'b1};
    localparam logic [31:0]     c_DEPTH_W = 32'(Depth);

    localparam logic [1:0] c_IDLE    = 2'd0;
    localparam logic [1:0] c_PAYLOAD = 2'd1;
`ifdef PKT_TX_PAD_EN
    localparam logic [1:0] c_PAD     = 2'd2;
`endif

    logic [Data_width-1:0] mem_q [Depth];
    logic [c_AW:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [1:0]            state_q, state_d;
    logic [Data_width-1:0] len_q, len_d, beat_cnt_q, beat_cnt_d;
    logic [Data_width-1:0] m_data_q, m_data_d;
    logic                  m_valid_q, m_valid_d, m_last_q, m_last_d;
    logic                  cfg_err_q, cfg_err_d;

    logic [c_AW:0]         w_count;
    logic                  w_wr_fire, w_pop, w_slot_free, w_illegal, w_start;
    logic [Data_width-1:0] w_k_eff, w_plen, w_plen_q, w_cnt_inc, w_rd_data;

`ifdef PKT_TX_PAD_EN
    logic [Data_width-1:0] k_q, k_d;

    assign w_k_eff   = k_i;
    assign w_plen_q  = len_q - k_q;
    assign w_illegal = (len_i == '0) || (k_i >= len_i) || (32'(w_plen) > c_DEPTH_W);
`else
    logic w_unused_k;

    assign w_unused_k = ^k_i;
    assign w_k_eff    = '0;
    assign w_plen_q   = len_q;
    assign w_illegal  = (len_i == '0) || (32'(len_i) > c_DEPTH_W);
`endif

    assign w_count     = wr_ptr_q - rd_ptr_q;
    assign full_o      = (w_count == c_DEPTH);
    assign empty_o     = (w_count == '0);
    assign wr_ready_o  = !full_o;
    assign w_wr_fire   = wr_en_i && !full_o;
    assign w_rd_data   = mem_q[rd_ptr_q[c_AW-1:0]];
    assign w_plen      = len_i - w_k_eff;
    assign w_slot_free = !m_valid_q || m_ready_i;
    assign w_cnt_inc   = beat_cnt_q + c_ONE;
    // w_plen is only meaningful once the config has been found legal
    assign w_start     = (state_q == c_IDLE) && w_slot_free && !w_illegal &&
                         (32'(w_count) >= 32'(w_plen));

    always_ff @(posedge clk) begin
        if (w_wr_fire) begin
            mem_q[wr_ptr_q[c_AW-1:0]] <= wr_data_i;
        end
    end

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
`ifdef PKT_TX_PAD_EN
        k_d        = k_q;
`endif
        beat_cnt_d = beat_cnt_q;
        m_data_d   = m_data_q;
        m_valid_d  = m_valid_q;
        m_last_d   = m_last_q;
        cfg_err_d  = cfg_err_q || ((state_q == c_IDLE) && w_illegal);
        w_pop      = 1'b0;

        case (state_q)
            c_IDLE: begin
                if (w_start) begin
                    len_d      = len_i;
`ifdef PKT_TX_PAD_EN
                    k_d        = k_i;
`endif
                    w_pop      = 1'b1;
                    m_data_d   = w_rd_data;
                    m_valid_d  = 1'b1;
                    beat_cnt_d = c_ONE;
                    m_last_d   = 1'b0;
                    if (w_plen != c_ONE) begin
                        state_d = c_PAYLOAD;
`ifdef PKT_TX_PAD_EN
                    end else if (k_i != '0) begin
                        state_d = c_PAD;
`endif
                    end else begin
                        m_last_d = 1'b1;
                    end
                end else if (w_slot_free) begin
                    m_valid_d = 1'b0;
                    m_last_d  = 1'b0;
                end
            end
            c_PAYLOAD: begin
                if (w_slot_free) begin
                    w_pop      = 1'b1;
                    m_data_d   = w_rd_data;
                    m_valid_d  = 1'b1;
                    beat_cnt_d = w_cnt_inc;
                    m_last_d   = 1'b0;
                    if (w_cnt_inc == w_plen_q) begin
`ifdef PKT_TX_PAD_EN
                        if (k_q != '0) begin
                            state_d = c_PAD;
                        end else begin
                            state_d  = c_IDLE;
                            m_last_d = 1'b1;
                        end
`else
                        state_d  = c_IDLE;
                        m_last_d = 1'b1;
`endif
                    end
                end
            end
`ifdef PKT_TX_PAD_EN
            c_PAD: begin
                if (w_slot_free) begin
                    m_data_d   = '0;
                    m_valid_d  = 1'b1;
                    beat_cnt_d = w_cnt_inc;
                    m_last_d   = (w_cnt_inc == len_q);
                    if (w_cnt_inc == len_q) begin
                        state_d = c_IDLE;
                    end
                end
            end
`endif
            default: begin
                state_d = c_IDLE;
            end
        endcase

        wr_ptr_d = wr_ptr_q + (w_wr_fire ? c_PTR_ONE : '0);
        rd_ptr_d = rd_ptr_q + (w_pop ? c_PTR_ONE : '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= c_IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            len_q      <= '0;
`ifdef PKT_TX_PAD_EN
            k_q        <= '0;
`endif
            beat_cnt_q <= '0;
            m_data_q   <= '0;
            m_valid_q  <= 1'b0;
            m_last_q   <= 1'b0;
            cfg_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            len_q      <= len_d;
`ifdef PKT_TX_PAD_EN
            k_q        <= k_d;
`endif
            beat_cnt_q <= beat_cnt_d;
            m_data_q   <= m_data_d;
            m_valid_q  <= m_valid_d;
            m_last_q   <= m_last_d;
            cfg_err_q  <= cfg_err_d;
        end
    end

    assign m_data_o  = m_data_q;
    assign m_valid_o = m_valid_q;
    assign m_last_o  = m_last_q;
    assign cfg_err_o = cfg_err_q;

endmodule

`default_nettype wire

// File: tb/tb_axis_pad_packet_tx.sv
`default_nettype none
// ============================================================================
// Module  : tb_axis_pad_packet_tx
// Purpose : Packet-level model pushes expected beats into a scoreboard queue;
//           an independent monitor pops and compares every accepted beat.
// Rev     : 1.0  initial release
// ============================================================================

module tb_axis_pad_packet_tx;

`ifdef PKT_TX_PAD_EN
    localparam bit PAD_EN = 1'b1;
`else
    localparam bit PAD_EN = 1'b0;
`endif

    logic       clk     = 1'b0;
    logic       rst     = 1'b1;
    logic [7:0] wr_data = 8'h00;
    logic       wr_en   = 1'b0;
    logic       wr_ready;
    logic [7:0] len     = 8'd8;
    logic [7:0] k       = 8'd2;
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_last;
    logic       m_ready = 1'b1;
    logic       full;
    logic       empty;
    logic       cfg_err;

    int n_vec = 0, n_err = 0;
    int cyc = 0, hs_cnt = 0, last_cyc = 0;
    int cur_plen = 8, cur_k = 0;
    int rmode = 0;
    bit model_block = 1'b0, gap_chk = 1'b0, prev_last = 1'b0;
    logic [7:0] mq[$];
    logic [8:0] exp_q[$];

    axis_pad_packet_tx #(.Data_width(8), .Depth(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .wr_data_i (wr_data),
        .wr_en_i   (wr_en),
        .wr_ready_o(wr_ready),
        .len_i     (len),
        .k_i       (k),
        .m_data_o  (m_data),
        .m_valid_o (m_valid),
        .m_last_o  (m_last),
        .m_ready_i (m_ready),
        .full_o    (full),
        .empty_o   (empty),
        .cfg_err_o (cfg_err)
    );

    initial forever #5 clk = ~clk;
    initial forever begin @(posedge clk); cyc++; end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running, required completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Expected traffic: the byte stream is cut into plen-byte chunks, each
    // followed by k zero beats, with last on the final beat of the packet.
    task automatic model_push(input logic [7:0] b);
        logic [7:0] d;
        mq.push_back(b);
        if (!model_block) begin
            while (mq.size() >= cur_plen) begin
                for (int i = 0; i < cur_plen; i++) begin
                    d = mq.pop_front();
                    exp_q.push_back({(cur_k == 0) && (i == cur_plen - 1), d});
                end
                for (int i = 0; i < cur_k; i++) exp_q.push_back({i == cur_k - 1, 8'h00});
            end
        end
    endtask

    task automatic set_cfg(input int l, input int kk);
        len      = 8'(l);
        k        = 8'(kk);
        cur_k    = PAD_EN ? kk : 0;
        cur_plen = l - cur_k;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [7:0] b);
        bit ok;
        int guard = 0;
        wr_data = b;
        wr_en   = 1'b1;
        forever begin
            @(negedge clk);
            ok = wr_ready;
            step();
            if (ok) break;
            guard++;
            if (guard > 1000) begin
                n_vec++; n_err++;
                $display("FAIL write_timeout: wr_ready stayed 0, required 1");
                break;
            end
        end
        wr_en = 1'b0;
        if (ok) model_push(b);
    endtask

    task automatic drain();
        int t = 0;
        @(negedge clk);
        while ((exp_q.size() != 0 || m_valid) && t < 3000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 3000) begin
            n_vec++; n_err++;
            $display("FAIL drain_timeout: %0d beats outstanding, required 0", exp_q.size());
        end
        step();
    endtask

    task automatic do_reset();
        rst   = 1'b1;
        wr_en = 1'b0;
        mq.delete();
        exp_q.delete();
        model_block = 1'b0;
        step();
        step();
        set_cfg(8, 2);
        rst = 1'b0;
        step();
    endtask

    // m_ready driver: 0 always, 1 pattern 1,0,0,1, 2 random, 3 held low
    initial begin : rdy_drv
        logic [3:0] pat;
        int pidx;
        pat  = 4'b1001;
        pidx = 0;
        forever begin
            step();
            case (rmode)
                0: m_ready = 1'b1;
                1: begin m_ready = pat[pidx]; pidx = (pidx + 1) % 4; end
                2: m_ready = 1'($urandom_range(0, 1));
                default: m_ready = 1'b0;
            endcase
        end
    end

    initial begin : monitor
        logic [8:0] e;
        bit         st_pend;
        logic [7:0] st_d;
        logic       st_l;
        st_pend = 1'b0;
        st_d    = 8'h00;
        st_l    = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                st_pend = 1'b0;
            end else begin
                if (st_pend) begin
                    chk("stall_valid", 32'(m_valid), 32'd1);
                    chk("stall_data", 32'(m_data), 32'(st_d));
                    chk("stall_last", 32'(m_last), 32'(st_l));
                end
                if (m_valid && m_ready) begin
                    hs_cnt++;
                    if (exp_q.size() == 0) begin
                        n_vec++; n_err++;
                        $display("FAIL unexpected_beat: got data %0h last %0b, required no beat", m_data, m_last);
                    end else begin
                        e = exp_q.pop_front();
                        chk("beat_data", 32'(m_data), 32'(e[7:0]));
                        chk("beat_last", 32'(m_last), 32'(e[8]));
                    end
                    if (gap_chk && prev_last) chk("b2b_gap", 32'(cyc - last_cyc), 32'd1);
                    prev_last = m_last;
                    last_cyc  = cyc;
                    st_pend   = 1'b0;
                end else if (m_valid) begin
                    st_pend = 1'b1;
                    st_d    = m_data;
                    st_l    = m_last;
                end else begin
                    st_pend = 1'b0;
                end
            end
        end
    end

    initial begin : main
        int base, t, l, kk, pl, nb;
        set_cfg(8, 2);
        step();
        step();
        @(negedge clk);
        chk("rst_m_data", 32'(m_data), 32'd0);
        chk("rst_m_valid", 32'(m_valid), 32'd0);
        chk("rst_m_last", 32'(m_last), 32'd0);
        chk("rst_cfg_err", 32'(cfg_err), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_wr_ready", 32'(wr_ready), 32'd1);
        step();
        rst = 1'b0;
        step();

        // first packet, latency of m_valid after the final payload write
        rmode = 0;
        for (int i = 1; i <= cur_plen; i++) wr(8'(i));
        @(negedge clk);
        chk("latency_pre", 32'(m_valid), 32'd0);
        @(negedge clk);
        chk("latency_valid", 32'(m_valid), 32'd1);
        drain();

        // same traffic under a stalling sink
        rmode = 1;
        for (int i = 1; i <= cur_plen; i++) wr(8'(8'h10 + i));
        drain();

        // fill to full behind a held single-beat packet
        rmode = 3;
        step();
        step();
        set_cfg(1, 0);
        wr(8'hA0);
        step();
        step();
        set_cfg(4, 0);
        for (int i = 0; i < 16; i++) wr(8'(8'h60 + i));
        @(negedge clk);
        chk("fill_full", 32'(full), 32'd1);
        chk("fill_wr_ready", 32'(wr_ready), 32'd0);
        chk("fill_empty", 32'(empty), 32'd0);
        step();
        wr_data = 8'hEE;
        wr_en   = 1'b1;
        @(negedge clk);
        chk("drop_wr_ready", 32'(wr_ready), 32'd0);
        step();
        wr_en = 1'b0;
        rmode = 0;
        drain();
        chk("drained_empty", 32'(empty), 32'd1);

        // len == k: illegal only when padding exists
        set_cfg(4, 4);
        model_block = PAD_EN;
        for (int i = 0; i < 8; i++) wr(8'(8'h70 + i));
        drain();
        repeat (4) @(negedge clk);
        chk("cfg_err_flag", 32'(cfg_err), 32'(PAD_EN));
        chk("cfg_no_valid", 32'(m_valid), 32'd0);
        step();
        do_reset();
        @(negedge clk);
        chk("cfg_err_cleared", 32'(cfg_err), 32'd0);
        chk("reset_empty", 32'(empty), 32'd1);
        step();

        // two back-to-back packets
        set_cfg(5, 0);
        prev_last = 1'b0;
        gap_chk   = 1'b1;
        for (int i = 0; i < 10; i++) wr(8'(8'h50 + i));
        drain();
        gap_chk = 1'b0;

        // asynchronous reset while beat 3 of an 8-beat packet is presented
        set_cfg(8, 2);
        base = hs_cnt;
        for (int i = 0; i < cur_plen; i++) wr(8'(8'h80 + i));
        t = 0;
        while (hs_cnt < base + 2 && t < 200) begin @(negedge clk); t++; end
        if (t >= 200) begin
            n_vec++; n_err++;
            $display("FAIL arst_wait: %0d beats taken, required 2", hs_cnt - base);
        end
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_m_valid", 32'(m_valid), 32'd0);
        chk("arst_m_last", 32'(m_last), 32'd0);
        chk("arst_m_data", 32'(m_data), 32'd0);
        chk("arst_empty", 32'(empty), 32'd1);
        chk("arst_wr_ready", 32'(wr_ready), 32'd1);
        mq.delete();
        exp_q.delete();
        step();
        step();
        rst = 1'b0;
        step();
        for (int i = 0; i < cur_plen; i++) wr(8'(8'h30 + i));
        drain();

        // randomized legal configurations, random sink and write gaps
        for (int r = 0; r < 12; r++) begin
            if (PAD_EN) begin
                l  = $urandom_range(1, 24);
                pl = $urandom_range(1, (l < 16) ? l : 16);
                kk = l - pl;
            end else begin
                l  = $urandom_range(1, 16);
                kk = $urandom_range(0, 255);
            end
            set_cfg(l, kk);
            rmode = 2;
            nb = cur_plen * $urandom_range(1, 3);
            for (int i = 0; i < nb; i++) begin
                repeat ($urandom_range(0, 2)) step();
                wr(8'($urandom_range(0, 255)));
            end
            drain();
        end

        chk("final_cfg_err", 32'(cfg_err), 32'd0);
        chk("final_empty", 32'(empty), 32'd1);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
